// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the CPU's data bus.
//
// After reset the array is zeroed one word per cycle (busy high), then CPU
// loads and stores are served from a DEPTH x DATA_W array. A valid/ready
// preload port can write memory while the CPU is stalled (enable low). Store
// and load counters saturate at all-ones.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   enable                CPU running; CPU bus sampled only when high
//   d_addr, d_dataout     CPU address / store data
//   d_we                  1 = store, 0 = load
//   d_datain              load data, RD_LAT edges after the address is sampled
//   ld_valid/ld_ready     preload handshake, ld_addr/ld_data payload
//   busy                  high while the post-reset clear is running
//   wr_count, rd_count    saturating store / load counters
//
// RD_LAT must be 1 or 2.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   d_q;

  logic                st_fire, rd_fire, ld_fire;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_ptr == LAST_ADDR) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // clr_ptr wraps back to 0 after the last word since DEPTH == 2**ADDR_W.
  always_ff @(posedge clock) begin
    if (reset)                clr_ptr <= '0;
    else if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
  end

  assign busy     = (state_q == CLEAR);
  assign ld_ready = (state_q == READY) && !enable;

  assign st_fire = (state_q == READY) && enable && d_we;
  assign rd_fire = (state_q == READY) && enable && !d_we;
  // ld_ready already excludes enable, so CPU stores and preloads never collide.
  assign ld_fire = ld_valid && ld_ready;

  // ---------------------------------------------------------------- write port
  // Single write port shared by the clear pass, CPU stores and preloads.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = '0;
    if (!reset) begin
      if (busy) begin
        mem_we = 1'b1;
      end else if (st_fire) begin
        mem_we    = 1'b1;
        mem_waddr = d_addr;
        mem_wdata = d_dataout;
      end else if (ld_fire) begin
        mem_we    = 1'b1;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
      end
    end
  end

  // No reset on the array: contents come only from the clear pass.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------- read path
  // A load sampled one edge after a store to the same address reads the array
  // after that store has landed, so it sees the new data.
  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clock) begin
      if (reset)        d_q <= '0;
      else if (rd_fire) d_q <= mem[d_addr];
    end
  end else begin : g_lat2
    logic [DATA_W-1:0] rd_s1;
    logic              vld_pipe;

    // Stage 2 only advances behind a real load, so d_datain holds while stalled.
    always_ff @(posedge clock) begin
      if (reset) begin
        rd_s1    <= '0;
        vld_pipe <= 1'b0;
        d_q      <= '0;
      end else begin
        vld_pipe <= rd_fire;
        if (rd_fire)  rd_s1 <= mem[d_addr];
        if (vld_pipe) d_q   <= rd_s1;
      end
    end
  end

  assign d_datain = d_q;

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (st_fire && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (rd_fire && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Two instances share all inputs: u_l1 with
// RD_LAT=1 and u_l2 with RD_LAT=2, so every sequence checks both latencies.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset, enable, d_we, ld_valid;
  logic [7:0]  d_addr, ld_addr;
  logic [15:0] d_dataout, ld_data;

  logic [15:0] d1, d2, wr1, wr2, rd1, rd2;
  logic        ldr1, ldr2, busy1, busy2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .RD_LAT(1)) u_l1 (
    .clock(clock), .reset(reset), .enable(enable), .d_addr(d_addr),
    .d_dataout(d_dataout), .d_we(d_we), .d_datain(d1), .ld_valid(ld_valid),
    .ld_ready(ldr1), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy1),
    .wr_count(wr1), .rd_count(rd1));

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .RD_LAT(2)) u_l2 (
    .clock(clock), .reset(reset), .enable(enable), .d_addr(d_addr),
    .d_dataout(d_dataout), .d_we(d_we), .d_datain(d2), .ld_valid(ld_valid),
    .ld_ready(ldr2), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy2),
    .wr_count(wr2), .rd_count(rd2));

  typedef struct {
    logic        en, we;
    logic [7:0]  addr;
    logic [15:0] dout;
    logic        lv;
    logic [7:0]  la;
    logic [15:0] ldat;
    logic [15:0] e1, e2, ewr, erd;
    logic        eldr;
  } vec_t;

  vec_t vecs[19];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts cycles with busy high (bounded), checking ld_ready stays low and
  // both instances agree on busy throughout.
  task automatic count_busy(input string tag, input int exp_n);
    int n = 0;
    int bad = 0;
    while (busy1 && n < 400) begin
      if (ldr1 || ldr2 || !busy2) bad++;
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, n, exp_n);
    chk({tag, "_ldready_low_in_clear"}, bad, 0);
    chk({tag, "_busy2_done"}, busy2, 1'b0);
  endtask

  task automatic idle_bus();
    enable = 1'b0; d_we = 1'b0; d_addr = '0; d_dataout = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  initial begin
    // {en, we, addr, dout, lv, la, ldat, exp d1, exp d2, exp wr, exp rd, exp ld_ready}
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h03, 16'h1234, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 16'hA5A5, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'd0, 16'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h1234, 16'h0000, 16'd0, 16'd2, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'hA5A5, 16'h1234, 16'd0, 16'd3, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'hA5A5, 16'hA5A5, 16'd0, 16'd3, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'hA5A5, 16'hA5A5, 16'd0, 16'd3, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'hA5A5, 16'hA5A5, 16'd0, 16'd3, 1'b1};
    // enable rises with ld_valid high: preload of 9999 to 03 must be refused
    vecs[8]  = '{1'b1, 1'b0, 8'h03, 16'h0000, 1'b1, 8'h03, 16'h9999, 16'h1234, 16'hA5A5, 16'd0, 16'd4, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h1234, 16'h1234, 16'd0, 16'd5, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h21, 16'h00C3, 1'b0, 8'h00, 16'h0000, 16'h1234, 16'h1234, 16'd1, 16'd5, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h21, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h00C3, 16'h1234, 16'd1, 16'd6, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h22, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h00C3, 16'd1, 16'd7, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'd1, 16'd7, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h21, 16'h7777, 16'h0000, 16'h0000, 16'd1, 16'd7, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h21, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h7777, 16'h0000, 16'd1, 16'd8, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 8'hFF, 16'h0001, 1'b0, 8'h00, 16'h0000, 16'h7777, 16'h7777, 16'd2, 16'd8, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0001, 16'h7777, 16'd2, 16'd9, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0001, 16'h0001, 16'd2, 16'd9, 1'b1};

    // ---------------- reset and clear, with a refused preload during CLEAR
    idle_bus();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy1", busy1, 1'b1);
    chk("rst_busy2", busy2, 1'b1);
    chk("rst_ldready", {ldr1, ldr2}, 2'b00);
    chk("rst_d1", d1, 16'h0000);
    chk("rst_d2", d2, 16'h0000);
    chk("rst_counts", {wr1, rd1, wr2, rd2}, 64'h0);

    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 8'h10; ld_data = 16'hBEEF;
    count_busy("clr1", 256);
    ld_valid = 1'b0;
    chk("clr1_d_zero", {d1, d2}, 32'h0);
    chk("clr1_ldready_up", {ldr1, ldr2}, 2'b11);

    // ---------------- table: preload, run, latency, hold, turnaround
    for (int i = 0; i < 19; i++) begin
      enable = vecs[i].en; d_we = vecs[i].we; d_addr = vecs[i].addr;
      d_dataout = vecs[i].dout; ld_valid = vecs[i].lv; ld_addr = vecs[i].la;
      ld_data = vecs[i].ldat;
      step();
      chk($sformatf("v%0d_d1", i), d1, vecs[i].e1);
      chk($sformatf("v%0d_d2", i), d2, vecs[i].e2);
      chk($sformatf("v%0d_wr", i), {wr1, wr2}, {vecs[i].ewr, vecs[i].ewr});
      chk($sformatf("v%0d_rd", i), {rd1, rd2}, {vecs[i].erd, vecs[i].erd});
      chk($sformatf("v%0d_ldready", i), {ldr1, ldr2}, {vecs[i].eldr, vecs[i].eldr});
    end
    idle_bus();

    // ---------------- reset mid-clear restarts the full clear
    reset = 1'b1;
    step();
    chk("rst2_counts", {wr1, rd1, wr2, rd2}, 64'h0);
    chk("rst2_d", {d1, d2}, 32'h0);
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'h5A5A;
    for (int i = 0; i < 100; i++) step();
    chk("mid_busy", {busy1, busy2}, 2'b11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy("clr2", 256);
    // ld_valid held throughout; first READY edge accepts it
    step();
    ld_valid = 1'b0;
    enable = 1'b1; d_we = 1'b0; d_addr = 8'h00;
    step();
    chk("clr2_preload_d1", d1, 16'h5A5A);
    d_addr = 8'h21;
    step();
    chk("clr2_cleared_d1", d1, 16'h0000);
    chk("clr2_preload_d2", d2, 16'h5A5A);
    enable = 1'b0;
    step();
    chk("clr2_cleared_d2", d2, 16'h0000);
    chk("clr2_rd", {rd1, rd2}, {16'd2, 16'd2});

    // ---------------- wr_count saturation over 65540 stores
    enable = 1'b1; d_we = 1'b1;
    for (int i = 1; i <= 65540; i++) begin
      d_addr = 8'(i); d_dataout = 16'(i);
      step();
      if (i == 65534) chk("sat_wr_fffe", wr1, 16'hFFFE);
      if (i == 65535) chk("sat_wr_ffff", {wr1, wr2}, 32'hFFFF_FFFF);
    end
    chk("sat_wr_held", {wr1, wr2}, 32'hFFFF_FFFF);
    chk("sat_rd_unchanged", {rd1, rd2}, {16'd2, 16'd2});
    // last store: addr 8'(65540)=8'h04 data 16'(65540)=16'h0004
    d_we = 1'b0; d_addr = 8'h04;
    step();
    chk("sat_load_d1", d1, 16'h0004);
    chk("sat_rd_inc", rd1, 16'd3);
    idle_bus();
    step();
    chk("sat_load_d2", d2, 16'h0004);
    chk("sat_wr_final", wr1, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the CPU's data bus (d_addr / d_dataout / d_we / d_datain).
- Serves CPU loads and stores from a DEPTH x DATA_W array.
- Clears itself after reset.
- Provides a valid/ready preload port so the bench or a loader can fill memory while the CPU is stalled (enable low).
- Keeps saturating access counters for verification and performance checks.

Parameters:
ADDR_W, 8, width of d_addr / ld_addr
DATA_W, 16, data width of all data ports
DEPTH, 256, number of words; must equal 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  CPU running; CPU bus is sampled only when high
d_addr  input  ADDR_W  CPU data address
d_dataout  input  DATA_W  CPU store data (written to memory)
d_we  input  1  CPU store strobe; high = write, low = read
d_datain  output  DATA_W  load data returned to CPU
ld_valid  input  1  preload request
ld_ready  output  1  preload port can accept
ld_addr  input  ADDR_W  preload address
ld_data  input  DATA_W  preload data
busy  output  1  high while clearing; CPU and load accesses ignored
wr_count  output  16  CPU store count, saturating
rd_count  output  16  CPU load count, saturating

Behaviour:
- States: CLEAR, READY.
- Reset:
  - Enters CLEAR with clr_ptr=0.
  - Outputs: d_datain=0, ld_ready=0, busy=1, wr_count=0, rd_count=0.
  - Read pipeline registers are cleared.
- CLEAR:
  - Each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - After clr_ptr=DEPTH-1 is written, moves to READY next cycle, so busy is high for exactly DEPTH cycles after reset deasserts.
  - CPU bus, ld_valid and counters are ignored; d_datain stays 0.
- Reset asserted in any state, including mid-CLEAR: clr_ptr returns to 0 and the full clear restarts.
- READY, store: when enable=1 and d_we=1, mem[d_addr] <= d_dataout at that edge; wr_count++.
- READY, load: when enable=1 and d_we=0, the address is sampled and rd_count++.
  - RD_LAT=1: d_datain = mem[d_addr] after the next edge.
  - RD_LAT=2: d_datain updates one edge later (second register stage).
- enable=0: no CPU access; d_datain holds its last value; counters hold.
- Store followed by a load of the same address on the next cycle: the load returns the new data (the write completes before the read).
- Preload:
  - ld_ready = (state==READY) && !enable.
  - On ld_valid && ld_ready, mem[ld_addr] <= ld_data at that edge.
  - Preload never changes d_datain or the counters.
  - ld_valid while ld_ready=0 is not accepted. The requester must hold ld_valid and the payload until ld_ready is seen.
- enable rising while ld_valid is high: a preload on that same edge is not accepted, because ld_ready was already low.
- Counters saturate at 16'hFFFF and never wrap.
- Address wrap: d_addr and ld_addr are exactly ADDR_W bits. No out-of-range case exists.
- Array contents are never initialised by synthesis attributes. The CLEAR pass is the only initialisation.

Test Plan:
- Reset clear: hold reset 2 cycles, release, count busy cycles -> busy=1 for exactly 256 cycles. A preload of addr 8'h10 with data 16'hBEEF attempted during CLEAR -> ld_ready=0, and a later load of 8'h10 returns 16'h0000.
- Preload then run: after CLEAR with enable=0, preload addr 8'h03 = 16'h1234 and addr 8'hFF = 16'hA5A5. Raise enable and load 8'h03 then 8'hFF -> d_datain=16'h1234 one cycle after the first address and 16'hA5A5 one cycle after the second (RD_LAT=1); rd_count=2.
- Store/load turnaround: store 16'h00C3 to 8'h21, then load 8'h21 on the next cycle -> d_datain=16'h00C3; wr_count=1, rd_count=1.
- Latency 2: repeat the preload-then-run scenario with RD_LAT=2 -> each value appears exactly two edges after its address is sampled. Drop enable for 3 cycles -> d_datain holds 16'hA5A5.
- Reset mid-clear: assert reset at clear cycle 100 -> busy stays high for a full 256 cycles after release, and a preload to 8'h00 is refused until busy falls.
- Saturation: with a counter force or a long run, issue 65540 stores -> wr_count=16'hFFFF and it stays there; rd_count is unchanged.
